gpi_debounce: RTL and testbench

//  Conditions raw board inputs (switches, buttons) before they reach gp_i of the

---
 rtl/gpi_debounce_pkg.sv | 23 ++
 rtl/gpi_debounce_chan.sv | 64 ++++++
 rtl/gpi_debounce.sv | 62 ++++++
 tb/tb_gpi_debounce.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpi_debounce_pkg.sv
// Shared constants and configuration record for the GPI debounce block.
package gpi_debounce_pkg;

  localparam int unsigned DefaultWidth          = 8;
  localparam int unsigned DefaultDebounceCycles = 500000;
  localparam int unsigned SimDebounceCycles     = 4;

  typedef struct packed {
    int unsigned width;
    int unsigned debounce_cycles;
  } debounce_cfg_t;

  localparam debounce_cfg_t DefaultCfg = '{width: DefaultWidth,
                                           debounce_cycles: DefaultDebounceCycles};
  localparam debounce_cfg_t SimCfg     = '{width: DefaultWidth,
                                           debounce_cycles: SimDebounceCycles};

  // The counter only has to reach DebounceCycles-1, so $clog2 is enough bits.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/gpi_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and edge strobes.
module gpi_debounce_chan
  import gpi_debounce_pkg::*;
#(
  parameter int unsigned DebounceCycles = SimDebounceCycles
) (
  input  logic clk_sys_i,
  input  logic rst_sys_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CntW    = cnt_width(DebounceCycles);
  localparam logic [CntW-1:0] CntTerm = CntW'(DebounceCycles - 1);

  logic            s1_q, s2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // Any sample matching the current level restarts the stability window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntTerm) begin
      cnt_d   = '0;
      level_d = s2_q;
      rise_d  = s2_q;
      fall_d  = ~s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/gpi_debounce.sv
// Debounces Width raw board inputs; optional edge-pending interrupt logic is
// enabled by defining GPI_DEBOUNCE_IRQ_EN.
module gpi_debounce
  import gpi_debounce_pkg::*;
#(
  parameter int unsigned Width          = DefaultCfg.width,
  parameter int unsigned DebounceCycles = DefaultCfg.debounce_cycles
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] gp_rise_o,
  output logic [Width-1:0] gp_fall_o
`ifdef GPI_DEBOUNCE_IRQ_EN
  ,
  input  logic [Width-1:0] irq_en_i,
  input  logic [Width-1:0] irq_clr_i,
  output logic [Width-1:0] irq_pend_o,
  output logic             irq_o
`endif
);

  for (genvar i = 0; i < Width; i++) begin : g_chan
    gpi_debounce_chan #(
      .DebounceCycles(DebounceCycles)
    ) u_chan (
      .clk_sys_i(clk_sys_i),
      .rst_sys_i(rst_sys_i),
      .raw_i    (gp_raw_i[i]),
      .level_o  (gp_o[i]),
      .rise_o   (gp_rise_o[i]),
      .fall_o   (gp_fall_o[i])
    );
  end

`ifdef GPI_DEBOUNCE_IRQ_EN
  logic [Width-1:0] pend_q, pend_d;
  logic             irq_q;

  // A new edge outranks a clear arriving in the same cycle.
  always_comb begin
    pend_d = ((gp_rise_o | gp_fall_o) & irq_en_i) | (pend_q & ~irq_clr_i);
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= |pend_d;
    end
  end

  assign irq_pend_o = pend_q;
  assign irq_o      = irq_q;
`else
  // Without the interrupt option the block is purely the debounced channels.
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Directed and random checks of gpi_debounce against a window-based reference model.
module tb_gpi_debounce;

  localparam int W  = 8;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw;
  logic [W-1:0] gp, rise, fall;
`ifdef GPI_DEBOUNCE_IRQ_EN
  logic [W-1:0] irq_en, irq_clr, pend;
  logic         irq;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: s2 samples seen since reset, last DC kept.
  logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic [W-1:0] hist[$];
  int           valid;
`ifdef GPI_DEBOUNCE_IRQ_EN
  logic [W-1:0] m_pend;
  logic         m_irq;
`endif

  always #5 clk = ~clk;

  gpi_debounce #(.Width(W), .DebounceCycles(DC)) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .gp_raw_i  (raw),
    .gp_o      (gp),
    .gp_rise_o (rise),
    .gp_fall_o (fall)
`ifdef GPI_DEBOUNCE_IRQ_EN
    ,
    .irq_en_i  (irq_en),
    .irq_clr_i (irq_clr),
    .irq_pend_o(pend),
    .irq_o     (irq)
`endif
  );

  // A channel changes when its last DC synchronised samples (all after reset)
  // disagree with its current level.
  task automatic model_edge();
    logic [W-1:0] flip;
    bit           all_diff;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      hist.delete();
      valid = 0;
`ifdef GPI_DEBOUNCE_IRQ_EN
      m_pend = '0; m_irq = 1'b0;
`endif
    end else begin
`ifdef GPI_DEBOUNCE_IRQ_EN
      m_pend = ((m_rise | m_fall) & irq_en) | (m_pend & ~irq_clr);
      m_irq  = |m_pend;
`endif
      hist.push_back(m_s2);
      if (hist.size() > DC) void'(hist.pop_front());
      valid++;
      flip = '0;
      if (valid >= DC) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          foreach (hist[j]) if (hist[j][i] == m_out[i]) all_diff = 1'b0;
          flip[i] = all_diff;
        end
      end
      m_rise = flip & ~m_out;
      m_fall = flip & m_out;
      m_out  = m_out ^ flip;
      m_s2   = m_s1;
      m_s1   = raw;
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("gp_o", gp, m_out);
    check("gp_rise_o", rise, m_rise);
    check("gp_fall_o", fall, m_fall);
    check("rise_and_fall", rise & fall, '0);
`ifdef GPI_DEBOUNCE_IRQ_EN
    check("irq_pend_o", pend, m_pend);
    check("irq_o", {7'b0, irq}, {7'b0, m_irq});
`endif
  endtask

  initial begin
    rst = 1'b1;
    raw = '0;
`ifdef GPI_DEBOUNCE_IRQ_EN
    irq_en  = '0;
    irq_clr = '0;
`endif
    // 1: reset with pins low, then quiet
    repeat (3) tick();
    check("t1_reset_gp", gp, 8'h00);
    check("t1_reset_rise", rise, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t1_idle_gp", gp, 8'h00);
      check("t1_idle_strobes", rise | fall, 8'h00);
    end

    // 2: single-channel step, 6-edge latency
    raw = 8'h01;
    repeat (5) tick();
    check("t2_before", gp, 8'h00);
    tick();
    check("t2_gp0", gp, 8'h01);
    check("t2_rise", rise, 8'h01);
    tick();
    check("t2_rise_one_cycle", rise, 8'h00);

    // 3: 3-cycle glitch on bit 3 is rejected
    raw = 8'h09;
    repeat (3) tick();
    raw = 8'h01;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_gp", gp, 8'h01);
      check("t3_strobes", rise | fall, 8'h00);
    end

    // 4: multi-channel step 00 -> A5
    raw = 8'h00;
    repeat (10) tick();
    check("t4_settled", gp, 8'h00);
    raw = 8'hA5;
    repeat (5) tick();
    check("t4_before", gp, 8'h00);
    tick();
    check("t4_gp", gp, 8'hA5);
    check("t4_rise", rise, 8'hA5);
    tick();
    check("t4_rise_end", rise, 8'h00);

    // 5: reset mid-count with pins high
    raw = 8'hFF;
    repeat (8) tick();
    check("t5_all_high", gp, 8'hFF);
    raw = 8'hFD;
    repeat (4) tick();
    rst = 1'b1;
    raw = 8'hFF;
    tick();
    check("t5_rst_gp", gp, 8'h00);
    check("t5_rst_strobes", rise | fall, 8'h00);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t5_before", gp, 8'h00);
    tick();
    check("t5_gp", gp, 8'hFF);
    check("t5_rise", rise, 8'hFF);

`ifdef GPI_DEBOUNCE_IRQ_EN
    // 6: pending set beats same-cycle clear; disabled channel never pends
    irq_en = 8'h01;
    repeat (3) tick();
    raw = 8'hFE;
    repeat (6) tick();
    check("t6_fall0", fall, 8'h01);
    irq_clr = 8'h01;
    tick();
    irq_clr = 8'h00;
    check("t6_pend_set", pend, 8'h01);
    check("t6_irq_set", {7'b0, irq}, 8'h01);
    repeat (3) tick();
    check("t6_pend_hold", pend, 8'h01);
    irq_clr = 8'h01;
    tick();
    irq_clr = 8'h00;
    check("t6_pend_clr", pend, 8'h00);
    check("t6_irq_clr", {7'b0, irq}, 8'h00);
    raw = 8'hFC;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t6_bit1_no_pend", pend, 8'h00);
    end
    check("t6_bit1_fell", gp, 8'hFC);
`endif

    // Random phase: random patterns held for random lengths, occasional reset
    for (int n = 0; n < 300; n++) begin
      raw = W'($urandom);
`ifdef GPI_DEBOUNCE_IRQ_EN
      irq_en = W'($urandom);
`endif
      rst = ($urandom_range(0, 39) == 0);
      for (int k = $urandom_range(1, 8); k > 0; k--) begin
`ifdef GPI_DEBOUNCE_IRQ_EN
        irq_clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
`endif
        tick();
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
